// File: rtl/ex_m_stage.sv
// EX->MEM pipeline register built as a two-entry skid buffer; control fields are gated off on bubbles.
// Optional performance counters (stall_cnt, flush_cnt) are built when EXM_PERF_CNT_EN is defined.
//
// state | meaning
// EMPTY | no entry held, out_valid=0
// ONE   | main entry valid and presented to MEM
// TWO   | main and skid both valid, in_ready=0

module ex_m_stage #(
    parameter int DATA_W  = 8,
    parameter int RADDR_W = 2,
    parameter int SP_W    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic [RADDR_W-1:0] in_ra,
    input  logic [RADDR_W-1:0] in_rb,
    input  logic [DATA_W-1:0]  in_R_ra,
    input  logic [DATA_W-1:0]  in_R_rb,
    input  logic [DATA_W-1:0]  in_res,
    input  logic [SP_W-1:0]    in_SP,
    input  logic               in_RW,
    input  logic               in_SW1,
    input  logic               in_SW2,
    input  logic               in_out_ld,
    input  logic               in_MW,
    input  logic               in_SM1,
    input  logic               in_SM2,
    output logic [RADDR_W-1:0] ra,
    output logic [RADDR_W-1:0] rb,
    output logic [DATA_W-1:0]  R_ra,
    output logic [DATA_W-1:0]  R_rb,
    output logic [DATA_W-1:0]  res,
    output logic [SP_W-1:0]    SP,
    output logic               RW,
    output logic               SW1,
    output logic               SW2,
    output logic               out_ld,
    output logic               MW,
    output logic               SM1,
    output logic               SM2
`ifdef EXM_PERF_CNT_EN
    ,
    output logic [15:0]        stall_cnt,
    output logic [15:0]        flush_cnt
`endif
);

    localparam int CTL_W = 7;
    localparam int PAY_W = 2 * RADDR_W + 3 * DATA_W + SP_W + CTL_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               in_ready_q;
    logic [PAY_W-1:0]   main_q;
    logic [PAY_W-1:0]   skid_q;
    logic [PAY_W-1:0]   in_pay;
    logic               accept;
    logic               handoff;
    logic               load_main;
    logic               load_skid;
    logic               main_from_skid;

    assign in_pay = {in_ra, in_rb, in_R_ra, in_R_rb, in_res, in_SP,
                     in_RW, in_SW1, in_SW2, in_out_ld, in_MW, in_SM1, in_SM2};

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid && in_ready_q;
    assign handoff   = out_valid && out_ready;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d   = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (accept && handoff) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    state_d   = TWO;
                    load_skid = 1'b1;
                end else if (handoff) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (handoff) begin
                    state_d        = ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        // flush overrides everything, including a same-cycle accept
        if (flush) begin
            state_d        = EMPTY;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != TWO);
            if (load_main) begin
                main_q <= in_pay;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_pay;
            end
        end
    end

    assign {ra, rb, R_ra, R_rb, res, SP} = main_q[PAY_W-1:CTL_W];
    assign {RW, SW1, SW2, out_ld, MW, SM1, SM2} = main_q[CTL_W-1:0] & {CTL_W{out_valid}};

`ifdef EXM_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (flush && (flush_cnt != 16'hFFFF)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ex_m_stage.sv
// Self-checking bench for ex_m_stage against a queue-based reference model (capacity-2 FIFO).
// Counter checks are built when EXM_PERF_CNT_EN is defined.

module tb_ex_m_stage;

    typedef struct packed {
        logic [1:0] ra;
        logic [1:0] rb;
        logic [7:0] R_ra;
        logic [7:0] R_rb;
        logic [7:0] res;
        logic [1:0] SP;
        logic       RW;
        logic       SW1;
        logic       SW2;
        logic       out_ld;
        logic       MW;
        logic       SM1;
        logic       SM2;
    } pay_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready;
    logic out_valid;
    pay_t din = '0;
    pay_t dout;

    logic [1:0] ra, rb, SP;
    logic [7:0] R_ra, R_rb, res;
    logic       RW, SW1, SW2, out_ld, MW, SM1, SM2;
`ifdef EXM_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    int n_pass = 0;
    int n_total = 0;

    pay_t q[$];
    bit   m_rdy = 1'b1;

    always #5 clk = ~clk;

    ex_m_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .in_ra     (din.ra),
        .in_rb     (din.rb),
        .in_R_ra   (din.R_ra),
        .in_R_rb   (din.R_rb),
        .in_res    (din.res),
        .in_SP     (din.SP),
        .in_RW     (din.RW),
        .in_SW1    (din.SW1),
        .in_SW2    (din.SW2),
        .in_out_ld (din.out_ld),
        .in_MW     (din.MW),
        .in_SM1    (din.SM1),
        .in_SM2    (din.SM2),
        .ra        (ra),
        .rb        (rb),
        .R_ra      (R_ra),
        .R_rb      (R_rb),
        .res       (res),
        .SP        (SP),
        .RW        (RW),
        .SW1       (SW1),
        .SW2       (SW2),
        .out_ld    (out_ld),
        .MW        (MW),
        .SM1       (SM1),
        .SM2       (SM2)
`ifdef EXM_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    assign dout = {ra, rb, R_ra, R_rb, res, SP, RW, SW1, SW2, out_ld, MW, SM1, SM2};

    function automatic pay_t rand_pay();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[$bits(pay_t)-1:0];
    endfunction

    // One clock edge; the model is a FIFO of at most two entries, flush empties it.
    task automatic step();
        bit acc;
        bit hand;
        @(posedge clk);
        acc  = in_valid && m_rdy;
        hand = (q.size() > 0) && out_ready;
        if (flush) begin
            q.delete();
        end else begin
            if (hand) void'(q.pop_front());
            if (acc) q.push_back(din);
        end
        m_rdy = (q.size() < 2);
        #1;
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        q.delete();
        m_rdy = 1'b1;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || dout !== pay_t'(0)) begin
            $display("FAIL reset_state: out_valid=%b in_ready=%b out=%h, need 0/1/0", out_valid, in_ready, dout);
        end else n_pass++;
        rst_n = 1'b1;
        #4;
        // fill to two entries, then reset asynchronously between edges
        out_ready = 1'b0;
        in_valid  = 1'b1;
        din = rand_pay();
        step();
        din = rand_pay();
        step();
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL reset_fill_two: in_ready=%b, need 0", in_ready);
        else n_pass++;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || res !== 8'h00) begin
            $display("FAIL reset_async: out_valid=%b in_ready=%b res=%h, need 0/1/00", out_valid, in_ready, res);
        end else n_pass++;
        q.delete();
        m_rdy = 1'b1;
        #1;
        rst_n = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        din = rand_pay();
        step();
        n_total++;
        if (out_valid !== 1'b1 || dout !== din) begin
            $display("FAIL reset_first_accept: out_valid=%b out=%h, need 1/%h", out_valid, dout, din);
        end else n_pass++;
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_stream();
        logic [7:0] v[3];
        v[0] = 8'h11; v[1] = 8'h22; v[2] = 8'h33;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = rand_pay();
            din.res = v[i];
            step();
            n_total++;
            if (out_valid !== 1'b1 || res !== v[i] || in_ready !== 1'b1) begin
                $display("FAIL stream_%0d: out_valid=%b res=%h in_ready=%b, need 1/%h/1", i, out_valid, res, in_ready, v[i]);
            end else n_pass++;
        end
        in_valid = 1'b0;
        step();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL stream_drain: out_valid=%b, need 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        din = rand_pay();
        din.res = 8'hA5;
        step();
        n_total++;
        if (in_ready !== 1'b1 || res !== 8'hA5 || out_valid !== 1'b1) begin
            $display("FAIL stall_first: in_ready=%b res=%h out_valid=%b, need 1/a5/1", in_ready, res, out_valid);
        end else n_pass++;
        din = rand_pay();
        din.res = 8'h5A;
        step();
        n_total++;
        if (in_ready !== 1'b0 || res !== 8'hA5) begin
            $display("FAIL stall_second: in_ready=%b res=%h, need 0/a5", in_ready, res);
        end else n_pass++;
        in_valid = 1'b0;
        din = rand_pay();
        step();
        n_total++;
        if (in_ready !== 1'b0 || res !== 8'hA5) begin
            $display("FAIL stall_hold: in_ready=%b res=%h, need 0/a5", in_ready, res);
        end else n_pass++;
        out_ready = 1'b1;
        step();
        n_total++;
        if (res !== 8'h5A || in_ready !== 1'b1 || out_valid !== 1'b1) begin
            $display("FAIL stall_release: res=%h in_ready=%b out_valid=%b, need 5a/1/1", res, in_ready, out_valid);
        end else n_pass++;
        step();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL stall_drain: out_valid=%b, need 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        din = rand_pay();
        step();
        din = rand_pay();
        step();
        flush = 1'b1;
        din = rand_pay();
        step();
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL flush_state: out_valid=%b in_ready=%b, need 0/1", out_valid, in_ready);
        end else n_pass++;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL flush_drop: out_valid=%b, need 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_bubble();
        in_valid = 1'b0;
        din = rand_pay();
        din.RW = 1'b1; din.MW = 1'b1; din.out_ld = 1'b1;
        step();
        n_total++;
        if (RW !== 1'b0 || MW !== 1'b0 || out_ld !== 1'b0 || dout[6:0] !== 7'd0) begin
            $display("FAIL bubble_gate: ctl=%b, need 0000000", dout[6:0]);
        end else n_pass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            flush     = ($urandom_range(15) == 0);
            din = rand_pay();
            step();
            n_total++;
            if (out_valid !== (q.size() > 0) || in_ready !== m_rdy) begin
                $display("FAIL rand_hs_%0d: out_valid=%b in_ready=%b, need %b/%b", c, out_valid, in_ready, q.size() > 0, m_rdy);
            end else if (q.size() > 0 && dout !== q[0]) begin
                $display("FAIL rand_data_%0d: out=%h, need %h", c, dout, q[0]);
            end else if (q.size() == 0 && dout[6:0] !== 7'd0) begin
                $display("FAIL rand_bubble_%0d: ctl=%b, need 0000000", c, dout[6:0]);
            end else n_pass++;
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();
    endtask

`ifdef EXM_PERF_CNT_EN
    task automatic test_counters();
        async_reset();
        #6;
        n_total++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            $display("FAIL cnt_reset: stall=%0d flush=%0d, need 0/0", stall_cnt, flush_cnt);
        end else n_pass++;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        din = rand_pay();
        step();
        in_valid = 1'b0;
        repeat (5) step();
        out_ready = 1'b1;
        step();
        flush = 1'b1;
        repeat (2) step();
        flush = 1'b0;
        step();
        n_total++;
        if (stall_cnt !== 16'd5 || flush_cnt !== 16'd2) begin
            $display("FAIL cnt_values: stall=%0d flush=%0d, need 5/2", stall_cnt, flush_cnt);
        end else n_pass++;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (65540) step();
        n_total++;
        if (stall_cnt !== 16'hFFFF) $display("FAIL cnt_saturate: stall=%h, need ffff", stall_cnt);
        else n_pass++;
        out_ready = 1'b1;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_bubble();
        test_random();
`ifdef EXM_PERF_CNT_EN
        test_counters();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ex_m_stage.md
EX_M_STAGE -- requirements
Module: ex_m_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of R_ra, R_rb and res.
REQ-002 SHALL have parameter RADDR_W, default 2, width of ra and rb.
REQ-003 SHALL have parameter SP_W, default 2, width of SP.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; all state SHALL clear immediately on reset assertion, independent of clk.
REQ-005 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port flush, input, 1, kill all held entries.
REQ-008 SHALL have port in_valid, input, 1, EX offers a payload.
REQ-009 SHALL have port in_ready, output, 1, stage can accept; registered.
REQ-010 SHALL have port out_valid, output, 1, MEM payload valid.
REQ-011 SHALL have port out_ready, input, 1, MEM consumes the payload.
REQ-012 SHALL have inputs in_ra and in_rb (RADDR_W), in_R_ra, in_R_rb and in_res (DATA_W), and in_SP (SP_W), the EX payload fields.
REQ-013 SHALL have inputs in_RW, in_SW1, in_SW2, in_out_ld, in_MW, in_SM1 and in_SM2 (1 each), the EX control fields.
REQ-014 SHALL have outputs ra, rb, R_ra, R_rb, res, SP, RW, SW1, SW2, out_ld, MW, SM1 and SM2, the same fields toward MEM at the same widths.

Function
REQ-015 SHALL hold the payload in a two-entry skid structure (main and skid registers) controlled by states EMPTY, ONE and TWO.
REQ-016 SHALL accept an input on a clk edge when in_valid and in_ready are both 1, and hand off an output when out_valid and out_ready are both 1.
REQ-017 SHALL drive in_ready = 1 in EMPTY and ONE and 0 in TWO, and out_valid = 1 in ONE and TWO.
REQ-018 SHALL make these transitions: EMPTY->ONE on accept; ONE->TWO on accept without handoff (input to skid); ONE->EMPTY on handoff without accept; ONE->ONE on accept with handoff (input to main).
REQ-019 SHALL go TWO->ONE on handoff (skid moves to main); TWO SHALL otherwise hold.
REQ-020 SHALL give a one-cycle latency from accept to out_valid when MEM is not stalling.
REQ-021 SHALL present the main entry on the outputs, in order; no payload SHALL be lost or duplicated.
REQ-022 SHALL force RW, MW, out_ld, SW1, SW2, SM1 and SM2 to 0 while out_valid = 0; data fields MAY hold stale values.
REQ-023 SHALL give flush priority over all other events: next state EMPTY, both entries invalidated, and any same-cycle input dropped.
REQ-024 SHALL keep payload registers unchanged when the pipeline is stalled (out_ready = 0 and no accept).

Reset
REQ-025 SHALL, while rst_n = 0, go to EMPTY with in_ready = 1, out_valid = 0 and every payload output 0, both registers cleared.
REQ-026 SHALL, on reset mid-operation, discard held entries; the first accept after release SHALL proceed as from EMPTY.

Configuration
REQ-027 SHALL, with macro EXM_PERF_CNT_EN defined, add outputs stall_cnt (16) and flush_cnt (16); stall_cnt SHALL count cycles with out_valid=1 and out_ready=0, and flush_cnt SHALL count cycles with flush=1.
REQ-028 SHALL saturate both counters at 16'hFFFF and clear them on reset.
REQ-029 SHALL, without EXM_PERF_CNT_EN, omit those ports and counters entirely, with function otherwise identical.

Verification
REQ-030 SHALL test reset: rst_n=0 mid-TWO -> out_valid=0, in_ready=1, res=0 asynchronously.
REQ-031 SHALL test streaming: out_ready=1, in_valid=1, res=8'h11,8'h22,8'h33 -> res 8'h11,8'h22,8'h33 on successive cycles, one cycle late.
REQ-032 SHALL test stalls: out_ready=0, push 8'hA5 then 8'h5A -> in_ready=0 after the second; out_ready=1 -> A5 then 5A, in_ready back to 1.
REQ-033 SHALL test flush: state TWO, flush=1 with in_valid=1 -> out_valid=0, in_ready=1 next cycle, input dropped.
REQ-034 SHALL test bubble gating: EMPTY with RW=MW=out_ld=1 at input and in_valid=0 -> RW=MW=out_ld=0 at output.
REQ-035 SHALL test counters (EXM_PERF_CNT_EN): 5 stall cycles and 2 flushes -> stall_cnt=5, flush_cnt=2; a forced long stall -> stall_cnt holds at 16'hFFFF.
